core_inst_sequencer: RTL and testbench
======================================

Name: core_inst_sequencer

Overview:
- Autonomous per-core instruction sequencer. Replaces hand-driven bench stimulus with an FSM that emits the 19-bit core instruction word and the mem_in vector for one attention core.
- Sequences: Q memory write, K memory write, K load into the PE array, execute, ofifo-to-pmem drain, and per-row SFP normalization (acc/div handshake).
- Sits directly upstream of each core's inst/mem_in inputs in fullchip; one instance per core, each in that core's clock domain.

Parameters:
- bw, 4, Q/K element bit width
- pr, 16, elements per vector (mem_in width = pr*bw)
- col, 8, K vectors (PE columns)
- n_q, 8, Q vectors per run (≤16)
- gap_cyc, 10, idle cycles after K load and after execute
- div_wait, 3, cycles div_ready is held before sfp_out is captured

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a run when idle
- abort  in  1  synchronous abort to IDLE
- vec_in  in  pr*bw  host Q/K vector
- vec_valid  in  1  vec_in valid
- vec_ready  out  1  sequencer accepts vec_in this cycle
- fifo_empty  in  1  core ofifo empty flag
- sfp_out  in  bw_psum*col  core out bus (bw_psum = 2*bw+4)
- inst  out  19  core instruction word
- mem_in  out  pr*bw  core memory data
- res_data  out  bw_psum*col  captured normalized row
- res_valid  out  1  one-cycle pulse with res_data
- busy  out  1  high outside IDLE/DONE
- done  out  1  one-cycle pulse at end of run

Behaviour:
- inst layout, fixed and shared with the core:
  - [18] div_ready, [17] acc_ready, [16] ofifo_rd
  - [15:12] qkmem_add, [11:8] pmem_add
  - [7] execute, [6] load, [5] qmem_rd, [4] qmem_wr
  - [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr
- All outputs are registered. Reset: inst=0, mem_in=0, res_data=0, vec_ready=0, res_valid=0, busy=0, done=0, state=IDLE.
- States: IDLE → QWR → KWR → KLOAD → GAP1 → EXEC → GAP2 → DRAIN → SFP → DONE → IDLE.
- IDLE: start=1 → QWR. start is ignored in every other state.
- QWR: vec_ready=1.
  - On accept (valid&ready), next cycle: qmem_wr=1, qkmem_add=cnt, mem_in=vec_in, cnt++.
  - No accept: bubble with qmem_wr=0 and address held.
  - After n_q accepts → KWR with cnt=0.
- KWR: same rule, using kmem_wr and col accepts.
- KLOAD: col+1 cycles, indexed k=0..col. load=1 throughout; kmem_rd=1 for k≥1; qkmem_add=max(k-1,0).
  - Next cycle: all zero except load=1 for one extra cycle, then GAP1.
- GAP1/GAP2: gap_cyc cycles with inst=0.
- EXEC: n_q cycles; execute=1, qmem_rd=1, qkmem_add=0..n_q-1; then GAP2.
- DRAIN: in each cycle with fifo_empty=0, issue ofifo_rd=1, pmem_wr=1, pmem_add=row, row++. fifo_empty=1 → stall with both bits 0. After n_q rows → SFP with row=0.
- SFP, per row: pmem_rd=1 and pmem_add=row throughout.
  - Sub-counter s=0..8+div_wait-3:
    - s0–1: acc=0, div=0
    - s2–3: acc_ready=1
    - s4–5: acc=0
    - s6…s6+div_wait-1: div_ready=1
  - Final cycle: res_data ← sfp_out, res_valid pulses, row++.
  - After n_q rows: pmem_rd=0 → DONE.
- DONE: done=1 for one cycle, inst=0, → IDLE.
- abort in any state: next cycle inst=0, vec_ready=0, counters cleared, → IDLE, no done pulse.
- reset_n low mid-run: immediate clear of all state and outputs.
- Counters are 4-bit. qkmem_add/pmem_add never wrap within a run because n_q, col ≤ 16.

Decomposition:
- Shared package core_inst_pkg:
  - inst bit-position constants (INST_DIV … INST_PMEM_WR) and field slices
  - state enum
  - INST_W=19
- One natural sub-module: sfp_row_timer (sub-counter s plus acc/div/capture decode), reused by the dual-core top.

Test Plan:
- Full run with defaults, vec_valid always 1 → exactly 8 qmem_wr (addr 0..7), 8 kmem_wr, 9 load cycles plus 1 trailing load, 8 execute, 8 pmem_wr, 8 res_valid pulses; done asserts once. res_data matches the sfp golden value for core 0 rows 0..7.
- QWR backpressure: vec_valid toggles 1,0,1,0 → qmem_wr bubbles align with the gaps; qkmem_add is strictly sequential 0..7 with no skipped or duplicate address.
- DRAIN with fifo_empty=1 for 5 cycles after entry → no ofifo_rd/pmem_wr during those cycles; then 8 consecutive reads with pmem_add 0..7.
- SFP row timing: for row 3, acc_ready is high exactly 2 cycles starting 2 cycles after row start, div_ready is high 3 cycles, res_valid fires on cycle 9 of the row, and pmem_add=3 throughout.
- abort during EXEC at q=4 → inst=0 next cycle, busy=0, no done. A subsequent start reruns from qkmem_add=0.
- reset_n asserted mid-KLOAD → inst and mem_in zero asynchronously; start pulses while busy in a later run are ignored (exactly one done per run).

Source files
------------

// File: rtl/core_inst_pkg.sv
// Shared definitions for the per-core instruction sequencer: instruction word
// layout, sequencer states and a small helper that packs the two address fields.
package core_inst_pkg;

  localparam int INST_W        = 19;
  localparam int INST_DIV      = 18;
  localparam int INST_ACC      = 17;
  localparam int INST_OFIFO_RD = 16;
  localparam int INST_QK_HI    = 15;
  localparam int INST_QK_LO    = 12;
  localparam int INST_PM_HI    = 11;
  localparam int INST_PM_LO    = 8;
  localparam int INST_EXEC     = 7;
  localparam int INST_LOAD     = 6;
  localparam int INST_QMEM_RD  = 5;
  localparam int INST_QMEM_WR  = 4;
  localparam int INST_KMEM_RD  = 3;
  localparam int INST_KMEM_WR  = 2;
  localparam int INST_PMEM_RD  = 1;
  localparam int INST_PMEM_WR  = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_QWR,
    S_KWR,
    S_KLOAD,
    S_GAP1,
    S_EXEC,
    S_GAP2,
    S_DRAIN,
    S_SFP,
    S_DONE
  } seq_state_e;

  function automatic logic [INST_W-1:0] inst_addr(input logic [3:0] qk, input logic [3:0] pm);
    logic [INST_W-1:0] w;
    w = '0;
    w[INST_QK_HI:INST_QK_LO] = qk;
    w[INST_PM_HI:INST_PM_LO] = pm;
    return w;
  endfunction

endpackage

// File: rtl/core_inst_sequencer_if.sv
// Host/core-facing bundle of the sequencer: host vector stream, run control,
// core instruction/data outputs and captured normalized rows.
interface core_inst_sequencer_if
  import core_inst_pkg::*;
#(
  parameter int bw  = 4,
  parameter int pr  = 16,
  parameter int col = 8
);

  localparam int BW_PSUM = 2*bw + 4;

  logic                     start;
  logic                     abort;
  logic [pr*bw-1:0]         vec_in;
  logic                     vec_valid;
  logic                     vec_ready;
  logic                     fifo_empty;
  logic [BW_PSUM*col-1:0]   sfp_out;
  logic [INST_W-1:0]        inst;
  logic [pr*bw-1:0]         mem_in;
  logic [BW_PSUM*col-1:0]   res_data;
  logic                     res_valid;
  logic                     busy;
  logic                     done;

  modport master (
    output start, abort, vec_in, vec_valid, fifo_empty, sfp_out,
    input  vec_ready, inst, mem_in, res_data, res_valid, busy, done
  );

  modport slave (
    input  start, abort, vec_in, vec_valid, fifo_empty, sfp_out,
    output vec_ready, inst, mem_in, res_data, res_valid, busy, done
  );

endinterface

// File: rtl/sfp_row_timer.sv
// Per-row sub-counter for SFP normalization: decodes the acc_ready window,
// the div_ready window and the final (capture) cycle of each row.
module sfp_row_timer #(
  parameter int div_wait = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic acc,
  output logic div,
  output logic last
);

  localparam int S_LAST = 5 + div_wait;
  localparam int S_W    = $clog2(S_LAST + 1);

  logic [S_W-1:0] s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s <= '0;
    end else if (!en || last) begin
      s <= '0;
    end else begin
      s <= s + 1'b1;
    end
  end

  assign last = (s == S_W'(S_LAST));
  assign acc  = (s == S_W'(2)) || (s == S_W'(3));
  assign div  = (s >= S_W'(6));

endmodule

// File: rtl/core_inst_sequencer.sv
// Autonomous instruction sequencer for one attention core: writes Q/K, loads K,
// executes, drains ofifo into pmem and normalizes each row through the SFP.
module core_inst_sequencer
  import core_inst_pkg::*;
#(
  parameter int bw       = 4,
  parameter int pr       = 16,
  parameter int col      = 8,
  parameter int n_q      = 8,
  parameter int gap_cyc  = 10,
  parameter int div_wait = 3
) (
  input logic                  clk,
  input logic                  reset_n,
  core_inst_sequencer_if.slave bus
);

  localparam int BW_PSUM = 2*bw + 4;
  // Counter must hold col+1 (KLOAD tail), gap_cyc-1, n_q-1 and expose 4 address bits.
  localparam int M1      = (col + 1 > 15) ? col + 1 : 15;
  localparam int M2      = (gap_cyc > M1) ? gap_cyc : M1;
  localparam int CNT_MAX = (n_q > M2) ? n_q : M2;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  seq_state_e               state, state_d;
  logic [CNT_W-1:0]         cnt, cnt_d, cnt_m1, cnt_inc;
  logic [INST_W-1:0]        inst_q, inst_d;
  logic [pr*bw-1:0]         mem_in_q, mem_in_d;
  logic [BW_PSUM*col-1:0]   res_data_q, res_data_d;
  logic                     vec_ready_q, vec_ready_d;
  logic                     res_valid_q, res_valid_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
  logic                     accept;
  logic                     t_acc, t_div, t_last;

  assign accept = bus.vec_valid & vec_ready_q;

  sfp_row_timer #(.div_wait(div_wait)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      ((state == S_SFP) && !bus.abort),
    .acc     (t_acc),
    .div     (t_div),
    .last    (t_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      inst_q      <= '0;
      mem_in_q    <= '0;
      res_data_q  <= '0;
      vec_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      inst_q      <= inst_d;
      mem_in_q    <= mem_in_d;
      res_data_q  <= res_data_d;
      vec_ready_q <= vec_ready_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Every output is decided one cycle ahead and registered, so the instruction
  // for a given step appears on inst the cycle after the state that produced it.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    inst_d      = '0;
    mem_in_d    = mem_in_q;
    res_data_d  = res_data_q;
    vec_ready_d = 1'b0;
    res_valid_d = 1'b0;
    done_d      = 1'b0;
    cnt_m1      = cnt - 1'b1;
    cnt_inc     = cnt + 1'b1;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_QWR;
          cnt_d       = '0;
          vec_ready_d = 1'b1;
        end
      end
      S_QWR: begin
        vec_ready_d = 1'b1;
        if (accept) begin
          inst_d               = inst_addr(cnt[3:0], 4'd0);
          inst_d[INST_QMEM_WR] = 1'b1;
          mem_in_d             = bus.vec_in;
          if (cnt == CNT_W'(n_q - 1)) begin
            state_d = S_KWR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_KWR: begin
        vec_ready_d = 1'b1;
        if (accept) begin
          inst_d               = inst_addr(cnt[3:0], 4'd0);
          inst_d[INST_KMEM_WR] = 1'b1;
          mem_in_d             = bus.vec_in;
          if (cnt == CNT_W'(col - 1)) begin
            state_d     = S_KLOAD;
            cnt_d       = '0;
            vec_ready_d = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_KLOAD: begin
        // k=0 primes the array, k=1..col read K, k=col+1 is the trailing load.
        inst_d[INST_LOAD] = 1'b1;
        if ((cnt != '0) && (cnt <= CNT_W'(col))) begin
          inst_d[INST_KMEM_RD]             = 1'b1;
          inst_d[INST_QK_HI:INST_QK_LO]    = cnt_m1[3:0];
        end
        if (cnt == CNT_W'(col + 1)) begin
          state_d = S_GAP1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_GAP1, S_GAP2: begin
        if (cnt == CNT_W'(gap_cyc - 1)) begin
          state_d = (state == S_GAP1) ? S_EXEC : S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_EXEC: begin
        inst_d               = inst_addr(cnt[3:0], 4'd0);
        inst_d[INST_EXEC]    = 1'b1;
        inst_d[INST_QMEM_RD] = 1'b1;
        if (cnt == CNT_W'(n_q - 1)) begin
          state_d = S_GAP2;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DRAIN: begin
        if (!bus.fifo_empty) begin
          inst_d                = inst_addr(4'd0, cnt[3:0]);
          inst_d[INST_OFIFO_RD] = 1'b1;
          inst_d[INST_PMEM_WR]  = 1'b1;
          if (cnt == CNT_W'(n_q - 1)) begin
            state_d = S_SFP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_SFP: begin
        inst_d               = inst_addr(4'd0, cnt[3:0]);
        inst_d[INST_PMEM_RD] = 1'b1;
        inst_d[INST_ACC]     = t_acc;
        inst_d[INST_DIV]     = t_div;
        if (t_last) begin
          res_valid_d = 1'b1;
          res_data_d  = bus.sfp_out;
          if (cnt == CNT_W'(n_q - 1)) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (bus.abort) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      inst_d      = '0;
      mem_in_d    = mem_in_q;
      res_data_d  = res_data_q;
      vec_ready_d = 1'b0;
      res_valid_d = 1'b0;
      done_d      = 1'b0;
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  assign bus.inst      = inst_q;
  assign bus.mem_in    = mem_in_q;
  assign bus.res_data  = res_data_q;
  assign bus.vec_ready = vec_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Directed bench for core_inst_sequencer: a negedge monitor tallies the emitted
// instruction stream while one initial block steps through the scenarios.
module tb_core_inst_sequencer;
  import core_inst_pkg::*;

  localparam int BW    = 4;
  localparam int PR    = 16;
  localparam int COL   = 8;
  localparam int NQ    = 8;
  localparam int GAP   = 10;
  localparam int DW    = 3;
  localparam int BWP   = 2*BW + 4;
  localparam int LIMIT = 2000;

  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  core_inst_sequencer_if #(.bw(BW), .pr(PR), .col(COL)) bus ();

  core_inst_sequencer #(
    .bw(BW), .pr(PR), .col(COL), .n_q(NQ), .gap_cyc(GAP), .div_wait(DW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [PR*BW-1:0] pattern(input int i);
    return 64'h0123_4567_89AB_CDEF + 64'(i + 1) * 64'h1111_1111_1111_1111;
  endfunction

  function automatic logic [BWP*COL-1:0] golden(input logic [3:0] r);
    logic [BWP*COL-1:0] g;
    g = '0;
    for (int c = 0; c < COL; c++) g[c*BWP +: BWP] = 12'(r) * 12'd151 + 12'(c) * 12'd29 + 12'd7;
    return g;
  endfunction

  // Core model: SFP output follows the pmem row currently being read.
  assign bus.sfp_out = bus.inst[INST_PMEM_RD] ? golden(bus.inst[INST_PM_HI:INST_PM_LO]) : '0;

  int checks = 0;
  int errors = 0;

  // Monitor state (written only by the monitor)
  int cyc = 0;
  int n_qwr, n_kwr, n_load, n_krd, n_exec, n_pwr, n_resv, n_done;
  int q_err, k_err, kr_err, e_err, p_err, mem_err, res_err, b2b_q;
  int q_first, q_last, pwr_first, pwr_last, r3_len, r3_start;
  int tot_done = 0;
  logic [15:0] r3_acc, r3_div, r3_res;
  logic prev_busy = 1'b0;
  logic prev_qwr = 1'b0;
  logic [3:0] qk, pm;

  always @(negedge clk) begin
    cyc++;
    if (bus.busy && !prev_busy) begin
      n_qwr = 0; n_kwr = 0; n_load = 0; n_krd = 0; n_exec = 0; n_pwr = 0; n_resv = 0; n_done = 0;
      q_err = 0; k_err = 0; kr_err = 0; e_err = 0; p_err = 0; mem_err = 0; res_err = 0; b2b_q = 0;
      q_first = 0; q_last = 0; pwr_first = 0; pwr_last = 0; r3_len = 0; r3_start = 0;
      r3_acc = '0; r3_div = '0; r3_res = '0;
    end
    prev_busy = bus.busy;
    qk = bus.inst[INST_QK_HI:INST_QK_LO];
    pm = bus.inst[INST_PM_HI:INST_PM_LO];
    if (bus.inst[INST_QMEM_WR]) begin
      if (int'(qk) != n_qwr) q_err++;
      if (bus.mem_in !== pattern(n_qwr)) mem_err++;
      if (prev_qwr) b2b_q++;
      if (n_qwr == 0) q_first = cyc;
      q_last = cyc;
      n_qwr++;
    end
    prev_qwr = bus.inst[INST_QMEM_WR];
    if (bus.inst[INST_KMEM_WR]) begin
      if (int'(qk) != n_kwr) k_err++;
      if (bus.mem_in !== pattern(NQ + n_kwr)) mem_err++;
      n_kwr++;
    end
    if (bus.inst[INST_LOAD]) begin
      n_load++;
      if (bus.inst[INST_KMEM_RD]) begin
        if (int'(qk) != n_krd) kr_err++;
        n_krd++;
      end
    end
    if (bus.inst[INST_EXEC]) begin
      if (int'(qk) != n_exec || !bus.inst[INST_QMEM_RD]) e_err++;
      n_exec++;
    end
    if (bus.inst[INST_PMEM_WR]) begin
      if (int'(pm) != n_pwr || !bus.inst[INST_OFIFO_RD]) p_err++;
      if (n_pwr == 0) pwr_first = cyc;
      pwr_last = cyc;
      n_pwr++;
    end
    if (bus.inst[INST_PMEM_RD] && pm == 4'd3) begin
      if (r3_len == 0) r3_start = cyc;
      if (cyc - r3_start < 16) begin
        if (bus.inst[INST_ACC]) r3_acc[cyc - r3_start] = 1'b1;
        if (bus.inst[INST_DIV]) r3_div[cyc - r3_start] = 1'b1;
        if (bus.res_valid)      r3_res[cyc - r3_start] = 1'b1;
      end
      r3_len++;
    end
    if (bus.res_valid) begin
      if (bus.res_data !== golden(4'(n_resv))) res_err++;
      n_resv++;
    end
    if (bus.done) begin
      n_done++;
      tot_done++;
    end
  end

  // Stimulus state
  int   acc_idx = 0;
  logic last_acc = 1'b0;
  logic toggle_mode = 1'b0;
  logic empty_force = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    if (last_acc) acc_idx++;
    bus.vec_valid  = toggle_mode ? ~bus.vec_valid : 1'b1;
    bus.vec_in     = pattern(acc_idx);
    bus.fifo_empty = empty_force;
    last_acc       = bus.vec_valid && bus.vec_ready;
  endtask

  task automatic start_run(input string tag);
    acc_idx       = 0;
    last_acc      = 1'b0;
    bus.vec_valid = 1'b0;
    bus.start     = 1'b1;
    step();
    bus.start     = 1'b0;
    check({tag, "_busy"}, 128'(bus.busy), 128'(1));
    check({tag, "_vec_ready"}, 128'(bus.vec_ready), 128'(1));
  endtask

  task automatic wait_done(input string tag);
    int base;
    int n;
    base = tot_done;
    n = 0;
    while (tot_done == base && n < LIMIT) begin
      step();
      n++;
    end
    check({tag, "_done_seen"}, 128'(n < LIMIT), 128'(1));
  endtask

  initial begin
    int n;
    int base;
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.vec_in     = '0;
    bus.vec_valid  = 1'b0;
    bus.fifo_empty = 1'b0;
    repeat (3) step();

    check("rst_inst",      128'(bus.inst),      128'(0));
    check("rst_mem_in",    128'(bus.mem_in),    128'(0));
    check("rst_res_data",  128'(bus.res_data),  128'(0));
    check("rst_vec_ready", 128'(bus.vec_ready), 128'(0));
    check("rst_res_valid", 128'(bus.res_valid), 128'(0));
    check("rst_busy",      128'(bus.busy),      128'(0));
    check("rst_done",      128'(bus.done),      128'(0));
    reset_n = 1'b1;
    repeat (2) step();

    // Full run, vec_valid always high
    start_run("run1");
    wait_done("run1");
    check("run1_qwr_cnt",   128'(n_qwr),   128'(8));
    check("run1_qwr_seq",   128'(q_err),   128'(0));
    check("run1_qwr_span",  128'(q_last - q_first), 128'(7));
    check("run1_kwr_cnt",   128'(n_kwr),   128'(8));
    check("run1_kwr_seq",   128'(k_err),   128'(0));
    check("run1_mem_in",    128'(mem_err), 128'(0));
    check("run1_load_cnt",  128'(n_load),  128'(10));
    check("run1_kmem_rd",   128'(n_krd),   128'(8));
    check("run1_kmem_seq",  128'(kr_err),  128'(0));
    check("run1_exec_cnt",  128'(n_exec),  128'(8));
    check("run1_exec_seq",  128'(e_err),   128'(0));
    check("run1_pwr_cnt",   128'(n_pwr),   128'(8));
    check("run1_pwr_seq",   128'(p_err),   128'(0));
    check("run1_res_cnt",   128'(n_resv),  128'(8));
    check("run1_res_data",  128'(res_err), 128'(0));
    check("run1_res_last",  128'(bus.res_data), 128'(golden(4'd7)));
    check("run1_done_cnt",  128'(n_done),  128'(1));
    check("run1_busy_end",  128'(bus.busy), 128'(0));
    step();
    check("run1_done_pulse", 128'(bus.done), 128'(0));
    repeat (3) step();

    // QWR backpressure: vec_valid alternates
    toggle_mode = 1'b1;
    start_run("run2");
    wait_done("run2");
    toggle_mode = 1'b0;
    check("run2_qwr_cnt",  128'(n_qwr),   128'(8));
    check("run2_qwr_seq",  128'(q_err),   128'(0));
    check("run2_qwr_b2b",  128'(b2b_q),   128'(0));
    check("run2_qwr_span", 128'(q_last - q_first), 128'(14));
    check("run2_kwr_cnt",  128'(n_kwr),   128'(8));
    check("run2_mem_in",   128'(mem_err), 128'(0));
    repeat (3) step();

    // DRAIN stall, then SFP row timing
    empty_force = 1'b1;
    start_run("run3");
    n = 0;
    while (n_exec < NQ && n < LIMIT) begin
      step();
      n++;
    end
    check("run3_exec_reached", 128'(n < LIMIT), 128'(1));
    repeat (GAP + 5) step();
    check("run3_drain_stall", 128'(n_pwr), 128'(0));
    empty_force = 1'b0;
    wait_done("run3");
    check("run3_pwr_cnt",  128'(n_pwr),   128'(8));
    check("run3_pwr_seq",  128'(p_err),   128'(0));
    check("run3_pwr_span", 128'(pwr_last - pwr_first), 128'(7));
    check("run3_row3_len", 128'(r3_len),  128'(9));
    check("run3_row3_acc", 128'(r3_acc),  128'(16'h000C));
    check("run3_row3_div", 128'(r3_div),  128'(16'h01C0));
    check("run3_row3_res", 128'(r3_res),  128'(16'h0100));
    check("run3_res_data", 128'(res_err), 128'(0));
    repeat (3) step();

    // Abort during EXEC at q=4
    start_run("run4");
    n = 0;
    while (!(bus.inst[INST_EXEC] && bus.inst[INST_QK_HI:INST_QK_LO] == 4'd4) && n < LIMIT) begin
      step();
      n++;
    end
    check("run4_exec_q4", 128'(n < LIMIT), 128'(1));
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("run4_abort_inst",  128'(bus.inst),      128'(0));
    check("run4_abort_busy",  128'(bus.busy),      128'(0));
    check("run4_abort_ready", 128'(bus.vec_ready), 128'(0));
    base = tot_done;
    repeat (20) step();
    check("run4_no_done", 128'(tot_done - base), 128'(0));
    check("run4_idle",    128'(bus.busy),        128'(0));
    start_run("run4b");
    wait_done("run4b");
    check("run4b_qwr_cnt",  128'(n_qwr),  128'(8));
    check("run4b_qwr_seq",  128'(q_err),  128'(0));
    check("run4b_exec_cnt", 128'(n_exec), 128'(8));
    check("run4b_done_cnt", 128'(n_done), 128'(1));
    repeat (3) step();

    // Asynchronous reset mid-KLOAD
    start_run("run5");
    n = 0;
    while (!bus.inst[INST_LOAD] && n < LIMIT) begin
      step();
      n++;
    end
    check("run5_kload_reached", 128'(n < LIMIT), 128'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("run5_rst_inst",   128'(bus.inst),      128'(0));
    check("run5_rst_mem_in", 128'(bus.mem_in),    128'(0));
    check("run5_rst_busy",   128'(bus.busy),      128'(0));
    check("run5_rst_ready",  128'(bus.vec_ready), 128'(0));
    step();
    reset_n = 1'b1;
    repeat (2) step();

    // Start pulses while busy are ignored
    base = tot_done;
    start_run("run6");
    n = 0;
    while (tot_done == base && n < LIMIT) begin
      step();
      bus.start = (n == 5 || n == 40 || n == 90);
      n++;
    end
    bus.start = 1'b0;
    check("run6_done_seen", 128'(n < LIMIT), 128'(1));
    repeat (30) step();
    check("run6_one_done", 128'(tot_done - base), 128'(1));
    check("run6_idle",     128'(bus.busy),        128'(0));
    check("run6_qwr_cnt",  128'(n_qwr),           128'(8));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
